spi_bus_sequencer: RTL and testbench
====================================

SPI_BUS_SEQUENCER -- requirements
Module: spi_bus_sequencer

Interface
REQ-001 Parameter SAMPLE_DIV, default 1042, clock cycles per audio sample period (50 MHz / 48 kHz).
REQ-002 Parameter CLR_CYCLES, default 16, length of the DAC clear pulse after reset.
REQ-003 Parameter TIMEOUT, default 255, maximum cycles an engine enable stays high without its done.
REQ-004 clock  in  1  single system clock; all logic on its rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 gain_done, adc_done, dac_done  in  1 each  one-cycle completion pulses from the preamp, ADC and DAC SPI engines.
REQ-007 regain_req  in  1  one-cycle request to reprogram preamp gain.
REQ-008 clear_flags  in  1  one-cycle clear of sticky flags.
REQ-009 Egain, Eadc, Edac  out  1 each  engine enables; at most one high at any time; each owns the shared sck/mosi/miso bus while high.
REQ-010 spissb, sf_ce0, fpgainitb  out  1 each  deselects for other bus devices; constant 1.
REQ-011 dacclr  out  1  active-low DAC clear.
REQ-012 ampshdn  out  1  preamp shutdown; constant 0.
REQ-013 sample_tick  out  1  one-cycle pulse per sample period.
REQ-014 busy  out  1  high whenever an enable is high.
REQ-015 overrun, timeout  out  1 each  sticky error flags.

Function
REQ-016 A free-running counter SHALL count 0..SAMPLE_DIV-1, wrap to 0, and pulse sample_tick for one cycle at count SAMPLE_DIV-1.
REQ-017 States SHALL be CLR, INIT_GAIN, IDLE, ADC, DAC, GAIN.
REQ-018 CLR: dacclr=0 for CLR_CYCLES cycles, then go to INIT_GAIN with dacclr=1 for all later states.
REQ-019 INIT_GAIN: Egain=1 until gain_done, then IDLE; sample ticks during CLR/INIT_GAIN are discarded and do not set overrun.
REQ-020 IDLE: on sample_tick go to ADC with Eadc=1 on the next cycle (latency 1).
REQ-021 ADC: on adc_done go to DAC with Edac=1 on the next cycle; Eadc deasserts that same edge.
REQ-022 DAC: on dac_done go to IDLE (or GAIN if a regain is pending).
REQ-023 regain_req SHALL be latched as pending in any state and serviced from IDLE by GAIN (Egain=1 until gain_done); the pending bit clears on entry to GAIN.
REQ-024 sample_tick and pending regain in the same IDLE cycle: ADC wins; GAIN runs after DAC.
REQ-025 sample_tick arriving in ADC, DAC or GAIN SHALL be dropped and set overrun.
REQ-026 If an enable stays high TIMEOUT cycles without its done, the enable SHALL drop, the state SHALL return to IDLE, and timeout SHALL set; in INIT_GAIN, timeout returns to INIT_GAIN with the enable re-asserted.
REQ-027 Done pulses not matching the active enable SHALL be ignored.
REQ-028 clear_flags SHALL clear overrun and timeout; a set event in the same cycle wins.

Reset
REQ-029 On reset: state CLR, counters 0, dacclr=0, Egain/Eadc/Edac=0, sample_tick=0, busy=0, overrun=0, timeout=0, pending regain=0, spissb/sf_ce0/fpgainitb=1, ampshdn=0.
REQ-030 Reset mid-transfer SHALL drop all enables in the same cycle it is sampled and restart from CLR.

Structure
REQ-031 Shared package audio_pkg SHALL hold the state enum and the default SAMPLE_DIV, CLR_CYCLES and TIMEOUT constants.
REQ-032 One sub-module, sample_rate_timer, SHALL implement the REQ-016 counter and tick.

Verification
REQ-033 Reset release: dacclr low for exactly 16 cycles, then Egain=1; gain_done -> IDLE with Egain=0.
REQ-034 SAMPLE_DIV=20: ticks every 20 cycles; each tick -> Eadc next cycle; adc_done -> Edac; dac_done -> IDLE; enables never overlap.
REQ-035 Hold adc_done off for 255 cycles -> Eadc drops, timeout=1, state IDLE; clear_flags -> timeout=0.
REQ-036 Delay dac_done past the next tick -> overrun=1 and that tick produces no Eadc.
REQ-037 regain_req and tick in the same IDLE cycle -> ADC, DAC, then GAIN in order.
REQ-038 Assert reset while Edac=1 -> Edac=0 next cycle and the dacclr pulse restarts.

Source files
------------

// File: rtl/audio_pkg.sv
// Shared definitions for the audio SPI bus sequencer: state encoding,
// default timing constants and a small width helper for counters.
package audio_pkg;

  // 50 MHz system clock divided down to a 48 kHz audio sample period.
  localparam int DEF_SAMPLE_DIV = 1042;

  // Number of cycles the DAC clear line is held low after reset.
  localparam int DEF_CLR_CYCLES = 16;

  // Longest an engine enable may stay high waiting for its done pulse.
  localparam int DEF_TIMEOUT = 255;

  // Bus ownership states; at most one engine enable is high in any of them.
  typedef enum logic [2:0] {
    ST_CLR,
    ST_INIT_GAIN,
    ST_IDLE,
    ST_ADC,
    ST_DAC,
    ST_GAIN
  } seq_state_e;

  // Bits needed to hold values 0..n-1, never less than one bit.
  function automatic int count_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sample_rate_timer.sv
// Free-running sample period counter. Counts 0..SAMPLE_DIV-1, wraps to 0,
// and raises sample_tick for the single cycle the count sits at its last value.
module sample_rate_timer
  import audio_pkg::*;
#(
  parameter int SAMPLE_DIV = DEF_SAMPLE_DIV
) (
  input  logic clock,
  input  logic reset,
  output logic sample_tick
);

  localparam int CW = count_width(SAMPLE_DIV);
  localparam logic [CW-1:0] LAST = CW'(SAMPLE_DIV - 1);

  logic [CW-1:0] count;

  // Advance the sample counter every cycle, wrapping at the end of the period.
  always_ff @(posedge clock) begin
    if (reset) begin
      count <= '0;
    end else if (count == LAST) begin
      count <= '0;
    end else begin
      count <= count + 1'b1;
    end
  end

  // The tick is a pure decode of the registered count, so it is glitch-free
  // and low out of reset (count is 0 then).
  assign sample_tick = (count == LAST);

endmodule

// File: rtl/spi_bus_sequencer.sv
// Arbitrates the shared sck/mosi/miso bus between the preamp gain, ADC and
// DAC SPI engines. After reset it pulses the DAC clear, programs the preamp
// gain once, then runs one ADC conversion followed by one DAC update per
// sample period. Gain reprogramming requests are deferred until the bus is
// free, and stalled engines are released by a watchdog.
module spi_bus_sequencer
  import audio_pkg::*;
#(
  parameter int SAMPLE_DIV = DEF_SAMPLE_DIV,
  parameter int CLR_CYCLES = DEF_CLR_CYCLES,
  parameter int TIMEOUT    = DEF_TIMEOUT
) (
  input  logic clock,
  input  logic reset,
  input  logic gain_done,
  input  logic adc_done,
  input  logic dac_done,
  input  logic regain_req,
  input  logic clear_flags,
  output logic Egain,
  output logic Eadc,
  output logic Edac,
  output logic spissb,
  output logic sf_ce0,
  output logic fpgainitb,
  output logic dacclr,
  output logic ampshdn,
  output logic sample_tick,
  output logic busy,
  output logic overrun,
  output logic timeout
);

  localparam int CLR_W = count_width(CLR_CYCLES);
  localparam logic [CLR_W-1:0] CLR_LAST = CLR_W'(CLR_CYCLES - 1);
  localparam int TO_W = count_width(TIMEOUT);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

  seq_state_e      state;
  logic [CLR_W-1:0] clr_count;
  logic [TO_W-1:0]  wd_count;
  logic             regain_pending;

  logic active_en;
  logic active_done;
  logic wd_expired;
  logic tick_while_busy;

  sample_rate_timer #(
    .SAMPLE_DIV(SAMPLE_DIV)
  ) u_timer (
    .clock      (clock),
    .reset      (reset),
    .sample_tick(sample_tick)
  );

  // Other devices on the shared bus stay deselected; the preamp is never shut down.
  assign spissb    = 1'b1;
  assign sf_ce0    = 1'b1;
  assign fpgainitb = 1'b1;
  assign ampshdn   = 1'b0;

  assign active_en = Egain | Eadc | Edac;
  assign busy      = active_en;

  // Only the done pulse belonging to the engine that currently owns the bus counts.
  assign active_done = (state == ST_ADC && Eadc && adc_done)
                     | (state == ST_DAC && Edac && dac_done)
                     | ((state == ST_GAIN || state == ST_INIT_GAIN) && Egain && gain_done);

  assign wd_expired = active_en && !active_done && (wd_count == TO_LAST);

  // Ticks are only lost (and flagged) once normal operation has started.
  assign tick_while_busy = sample_tick
                         && (state == ST_ADC || state == ST_DAC || state == ST_GAIN);

  // Watchdog: count cycles an enable has been high without its done pulse.
  always_ff @(posedge clock) begin
    if (reset || !active_en || active_done || wd_expired) begin
      wd_count <= '0;
    end else begin
      wd_count <= wd_count + 1'b1;
    end
  end

  // Main sequencer: state, engine enables, DAC clear and pending regain.
  always_ff @(posedge clock) begin
    if (reset) begin
      state          <= ST_CLR;
      clr_count      <= '0;
      dacclr         <= 1'b0;
      Egain          <= 1'b0;
      Eadc           <= 1'b0;
      Edac           <= 1'b0;
      regain_pending <= 1'b0;
    end else begin
      case (state)
        ST_CLR: begin
          if (clr_count == CLR_LAST) begin
            state  <= ST_INIT_GAIN;
            dacclr <= 1'b1;
            Egain  <= 1'b1;
          end else begin
            clr_count <= clr_count + 1'b1;
          end
        end

        ST_INIT_GAIN: begin
          // A stalled initial gain load is retried: drop the enable for a
          // cycle so the engine restarts, then raise it again.
          if (!Egain) begin
            Egain <= 1'b1;
          end else if (gain_done) begin
            Egain <= 1'b0;
            state <= ST_IDLE;
          end else if (wd_expired) begin
            Egain <= 1'b0;
          end
        end

        ST_IDLE: begin
          // A sample tick takes priority; a pending regain waits for the DAC.
          if (sample_tick) begin
            state <= ST_ADC;
            Eadc  <= 1'b1;
          end else if (regain_pending) begin
            state          <= ST_GAIN;
            Egain          <= 1'b1;
            regain_pending <= 1'b0;
          end
        end

        ST_ADC: begin
          if (adc_done) begin
            Eadc  <= 1'b0;
            Edac  <= 1'b1;
            state <= ST_DAC;
          end else if (wd_expired) begin
            Eadc  <= 1'b0;
            state <= ST_IDLE;
          end
        end

        ST_DAC: begin
          if (dac_done) begin
            Edac <= 1'b0;
            if (regain_pending) begin
              state          <= ST_GAIN;
              Egain          <= 1'b1;
              regain_pending <= 1'b0;
            end else begin
              state <= ST_IDLE;
            end
          end else if (wd_expired) begin
            Edac  <= 1'b0;
            state <= ST_IDLE;
          end
        end

        ST_GAIN: begin
          if (gain_done || wd_expired) begin
            Egain <= 1'b0;
            state <= ST_IDLE;
          end
        end

        default: begin
          state <= ST_CLR;
          Egain <= 1'b0;
          Eadc  <= 1'b0;
          Edac  <= 1'b0;
        end
      endcase

      // A new request arriving as GAIN is entered must not be lost.
      if (regain_req) begin
        regain_pending <= 1'b1;
      end
    end
  end

  // Sticky error flags; a setting event beats a simultaneous clear.
  always_ff @(posedge clock) begin
    if (reset) begin
      overrun <= 1'b0;
      timeout <= 1'b0;
    end else begin
      if (tick_while_busy) begin
        overrun <= 1'b1;
      end else if (clear_flags) begin
        overrun <= 1'b0;
      end

      if (wd_expired) begin
        timeout <= 1'b1;
      end else if (clear_flags) begin
        timeout <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_spi_bus_sequencer.sv
// Self-checking bench for spi_bus_sequencer. Expected enable order is queued
// as stimulus is driven and popped whenever an engine enable rises.
module tb_spi_bus_sequencer;

  localparam int SampleDiv     = 20;
  localparam int ClrCycles     = 16;
  localparam int TimeoutCycles = 255;

  localparam int EnGain = 1;
  localparam int EnAdc  = 2;
  localparam int EnDac  = 3;

  localparam int StimGainDone = 1;
  localparam int StimAdcDone  = 2;
  localparam int StimDacDone  = 3;
  localparam int StimRegain   = 4;
  localparam int StimClear    = 5;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic gain_done = 1'b0;
  logic adc_done = 1'b0;
  logic dac_done = 1'b0;
  logic regain_req = 1'b0;
  logic clear_flags = 1'b0;
  logic Egain, Eadc, Edac;
  logic spissb, sf_ce0, fpgainitb;
  logic dacclr, ampshdn, sample_tick, busy, overrun, timeout;

  int testsRun = 0;
  int failCount = 0;
  int cycleCount = 0;
  int overlapCount = 0;
  int expQ[$];
  logic prevGain = 1'b0;
  logic prevAdc = 1'b0;
  logic prevDac = 1'b0;

  spi_bus_sequencer #(
    .SAMPLE_DIV(SampleDiv),
    .CLR_CYCLES(ClrCycles),
    .TIMEOUT   (TimeoutCycles)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .gain_done  (gain_done),
    .adc_done   (adc_done),
    .dac_done   (dac_done),
    .regain_req (regain_req),
    .clear_flags(clear_flags),
    .Egain      (Egain),
    .Eadc       (Eadc),
    .Edac       (Edac),
    .spissb     (spissb),
    .sf_ce0     (sf_ce0),
    .fpgainitb  (fpgainitb),
    .dacclr     (dacclr),
    .ampshdn    (ampshdn),
    .sample_tick(sample_tick),
    .busy       (busy),
    .overrun    (overrun),
    .timeout    (timeout)
  );

  // 100 MHz bench clock.
  always #5 clock = ~clock;

  // Free-running cycle count used to measure tick spacing.
  always @(posedge clock) cycleCount <= cycleCount + 1;

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
    end
  endtask

  // Scoreboard: every enable rising edge must match the next queued expectation.
  always @(negedge clock) begin
    int risen;
    risen = 0;
    if (Egain && !prevGain) risen = EnGain;
    else if (Eadc && !prevAdc) risen = EnAdc;
    else if (Edac && !prevDac) risen = EnDac;
    if (risen != 0) begin
      if (expQ.size() == 0) checkOutput("unexpected_enable", risen, 0);
      else checkOutput("enable_order", risen, expQ.pop_front());
    end
    if ((int'(Egain) + int'(Eadc) + int'(Edac)) > 1) overlapCount++;
    prevGain = Egain;
    prevAdc  = Eadc;
    prevDac  = Edac;
  end

  // Drive a one-cycle pulse starting at the current negedge.
  task automatic applyStimulus(input int kind);
    case (kind)
      StimGainDone: gain_done = 1'b1;
      StimAdcDone:  adc_done = 1'b1;
      StimDacDone:  dac_done = 1'b1;
      StimRegain:   regain_req = 1'b1;
      default:      clear_flags = 1'b1;
    endcase
    @(negedge clock);
    gain_done = 1'b0;
    adc_done = 1'b0;
    dac_done = 1'b0;
    regain_req = 1'b0;
    clear_flags = 1'b0;
  endtask

  task automatic waitForTick();
    int n;
    n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (!sample_tick && n < 60);
    if (!sample_tick) checkOutput("tick_wait", 0, 1);
  endtask

  // Count cycles from reset release until dacclr returns high.
  task automatic countDacclrLow(input string tag);
    int n;
    n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (!dacclr && n < 100);
    checkOutput(tag, n, ClrCycles);
    checkOutput({tag, "_egain"}, Egain, 1);
  endtask

  // Service one complete ADC then DAC frame; called on the tick cycle.
  task automatic runFrame();
    expQ.push_back(EnAdc);
    expQ.push_back(EnDac);
    @(negedge clock);
    checkOutput("adc_latency", Eadc, 1);
    @(negedge clock);
    applyStimulus(StimAdcDone);
    checkOutput("adc_to_dac", {Eadc, Edac}, 2'b01);
    @(negedge clock);
    applyStimulus(StimDacDone);
    checkOutput("dac_to_idle", busy, 0);
  endtask

  initial begin
    int lastTick;
    int hi;
    int n;
    lastTick = 0;

    // Reset state and DAC clear pulse.
    expQ.push_back(EnGain);
    repeat (3) @(negedge clock);
    checkOutput("rst_dacclr", dacclr, 0);
    checkOutput("rst_enables", {Egain, Eadc, Edac}, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_flags", {overrun, timeout}, 0);
    checkOutput("rst_tick", sample_tick, 0);
    checkOutput("rst_deselects", {spissb, sf_ce0, fpgainitb}, 3'b111);
    checkOutput("rst_ampshdn", ampshdn, 0);
    reset = 1'b0;
    countDacclrLow("dacclr_low_cycles");

    // Hold the initial gain load across a tick, which must be discarded.
    repeat (10) @(negedge clock);
    applyStimulus(StimGainDone);
    checkOutput("init_gain_done", {Egain, busy}, 2'b00);
    checkOutput("init_tick_no_overrun", overrun, 0);

    // Normal frames and tick spacing.
    for (int f = 0; f < 3; f++) begin
      waitForTick();
      if (f > 0) checkOutput("tick_period", cycleCount - lastTick, SampleDiv);
      lastTick = cycleCount;
      runFrame();
    end

    // ADC never completes: watchdog releases the bus.
    waitForTick();
    expQ.push_back(EnAdc);
    hi = 0;
    do begin
      @(negedge clock);
      if (Eadc) hi++;
    end while (Eadc && hi < 400);
    checkOutput("timeout_en_cycles", hi, TimeoutCycles);
    checkOutput("timeout_flag", timeout, 1);
    checkOutput("timeout_idle", busy, 0);
    applyStimulus(StimClear);
    checkOutput("timeout_cleared", {overrun, timeout}, 0);

    // DAC held past the next tick: tick dropped, overrun flagged.
    waitForTick();
    expQ.push_back(EnAdc);
    expQ.push_back(EnDac);
    @(negedge clock);
    checkOutput("ovr_adc_start", Eadc, 1);
    applyStimulus(StimAdcDone);
    checkOutput("ovr_dac_start", Edac, 1);
    n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (!sample_tick && n < 40);
    checkOutput("ovr_tick_in_dac", {sample_tick, Edac}, 2'b11);
    @(negedge clock);
    checkOutput("overrun_set", overrun, 1);
    checkOutput("ovr_no_adc", Eadc, 0);
    applyStimulus(StimDacDone);
    checkOutput("ovr_dac_idle", busy, 0);
    repeat (3) @(negedge clock);
    checkOutput("ovr_tick_dropped", Eadc, 0);
    applyStimulus(StimClear);
    checkOutput("overrun_cleared", overrun, 0);

    // Regain request together with a tick: ADC, DAC, then GAIN.
    waitForTick();
    regain_req = 1'b1;
    expQ.push_back(EnAdc);
    expQ.push_back(EnDac);
    expQ.push_back(EnGain);
    @(negedge clock);
    regain_req = 1'b0;
    checkOutput("regain_adc_first", {Egain, Eadc}, 2'b01);
    @(negedge clock);
    applyStimulus(StimAdcDone);
    checkOutput("regain_dac", Edac, 1);
    applyStimulus(StimDacDone);
    checkOutput("regain_after_dac", {Egain, Edac}, 2'b10);
    applyStimulus(StimGainDone);
    checkOutput("regain_idle", busy, 0);

    // Reset during a DAC transfer.
    waitForTick();
    expQ.push_back(EnAdc);
    expQ.push_back(EnDac);
    @(negedge clock);
    applyStimulus(StimAdcDone);
    checkOutput("mid_dac_active", Edac, 1);
    expQ.push_back(EnGain);
    reset = 1'b1;
    @(negedge clock);
    checkOutput("reset_drops_dac", {Egain, Eadc, Edac}, 0);
    checkOutput("reset_dacclr", dacclr, 0);
    reset = 1'b0;
    countDacclrLow("dacclr_restart");
    applyStimulus(StimGainDone);
    checkOutput("reinit_idle", busy, 0);
    waitForTick();
    runFrame();

    repeat (5) @(negedge clock);
    checkOutput("queue_drained", expQ.size(), 0);
    checkOutput("no_overlap", overlapCount, 0);

    $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
    $finish;
  end

  // Absolute bound on run time.
  initial begin
    #200000;
    $display("[TB] FAIL global_timeout: got %0d cycles, expected completion", cycleCount);
    $fatal(1, "[TB] simulation did not complete");
  end

endmodule
